downstream_vc_tracker: RTL

Per-router controller that owns the state of every downstream Virtual Channel: it counts credits per downstream VC, follows each one through reserved/active/draining/idle, and drives the idle vector consumed by the VC allocator. Its idle output lets the allocator release downstream VCs. Its credit output lets the switch allocator gate requests.

---
 rtl/downstream_vc_tracker.sv | 108 ++++++++++
 1 files changed

// File: rtl/downstream_vc_tracker.sv
// Downstream VC state and credit tracker.
// Drives the idle and credit vectors seen by the VC and switch allocators.
module downstream_vc_tracker #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int VC_TOTAL    = PORT_NUM * VC_NUM,
  parameter int BUFFER_SIZE = 8,
  parameter int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [VC_TOTAL-1:0]                alloc_i,
  input  logic [PORT_NUM-1:0]                sent_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]   sent_vc_i,
  input  logic [PORT_NUM-1:0]                sent_tail_i,
  input  logic [PORT_NUM-1:0]                credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]   credit_vc_i,
  output logic [VC_TOTAL-1:0]                idle_downstream_vc_o,
  output logic [VC_TOTAL-1:0]                has_credit_o,
  output logic                               error_o
);

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    RESERVED,
    ACTIVE,
    DRAINING
  } vc_state_e;

  logic [VC_TOTAL-1:0] err_vc;
  logic                error_q;

  for (genvar g = 0; g < VC_TOTAL; g++) begin : g_vc
    localparam int P = g / VC_NUM;
    localparam int V = g % VC_NUM;

    vc_state_e        st_q;
    vc_state_e        st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec;
    logic             inc;
    logic             tail;
    logic             err;

    assign dec  = sent_valid_i[P] && (sent_vc_i[P] == VC_SIZE'(V));
    assign inc  = credit_valid_i[P] && (credit_vc_i[P] == VC_SIZE'(V));
    assign tail = sent_tail_i[P];

    always_comb begin
      cnt_d = cnt_q;
      st_d  = st_q;
      err   = 1'b0;
      // Saturate on both ends; a bad event flags but never wraps.
      if (dec && !inc) begin
        if (cnt_q == '0) err = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end else if (inc && !dec) begin
        if (cnt_q == FULL) err = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      unique case (st_q)
        IDLE: begin
          if (dec) err = 1'b1;
          if (alloc_i[g]) st_d = RESERVED;
        end
        RESERVED: begin
          if (alloc_i[g]) err = 1'b1;
          if (dec) st_d = tail ? DRAINING : ACTIVE;
        end
        ACTIVE: begin
          if (alloc_i[g]) err = 1'b1;
          if (dec && tail) st_d = DRAINING;
        end
        DRAINING: begin
          if (alloc_i[g] || dec) err = 1'b1;
          else if (cnt_d == FULL) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= IDLE;
        cnt_q <= FULL;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign err_vc[g]               = err;
    assign idle_downstream_vc_o[g] = (st_q == IDLE);
    assign has_credit_o[g]         = (cnt_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_q | (|err_vc);
  end

  assign error_o = error_q;

endmodule
